// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO types and helpers for the write side
// (wptr_full) and the read side (rptr_empty).
//   ADDR_WIDTH : memory address bits
//   DEPTH      : entries, 2**ADDR_WIDTH
//   PTR_WIDTH  : pointer bits; the extra MSB tells wrap parity apart
//   ptr_t      : pointer type
//   bin2gray / gray2bin : pointer code conversions
package fifo_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

  typedef logic [PTR_WIDTH-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a multi-bit Gray bus.
//   clk : destination-domain clock
//   rst : synchronous, active-high reset (clears both stages)
//   d   : asynchronous input, at most one bit changing at a time
//   q   : synchronised output, two clk edges after d
module sync_2ff #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end
endmodule

// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer and full/level generator for the async FIFO.
//   w_clk, w_rst   : write clock, synchronous active-high reset
//   w_en           : producer write request
//   r_ptr_gray     : Gray read pointer from the read domain (async)
//   w_inc          : accepted write (w_en & ~full), fifo_mem write enable
//   w_addr         : fifo_mem write address
//   w_ptr_gray     : registered Gray write pointer for the read side
//   full           : registered full flag
//   almost_full    : free entries <= AF_MARGIN
//   w_level        : registered fill level, 0..DEPTH
//   overflow       : sticky, a write was attempted while full
// ADDR_WIDTH must match fifo_pkg::ADDR_WIDTH, whose helpers size the pointers.
module wptr_full #(
  parameter int ADDR_WIDTH = 5,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic                  w_inc,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  overflow
);
  import fifo_pkg::*;

  localparam int PW       = ADDR_WIDTH + 1;
  localparam int DEPTH_L  = 1 << ADDR_WIDTH;
  localparam int AF_LEVEL = DEPTH_L - AF_MARGIN;

  logic [PW-1:0] wbin, wbin_next, wgray_next;
  logic [PW-1:0] rq2, rbin, lvl_next, full_gray;

  assign w_inc      = w_en & ~full;
  assign w_addr     = wbin[ADDR_WIDTH-1:0];
  assign wbin_next  = wbin + PW'(w_inc);
  assign wgray_next = bin2gray(wbin_next);

  sync_2ff #(.WIDTH(PW)) u_rsync (
    .clk (w_clk),
    .rst (w_rst),
    .d   (r_ptr_gray),
    .q   (rq2)
  );

  assign rbin = gray2bin(rq2);

  // Modulo subtraction: the pointer MSB absorbs the wrap, so the result
  // stays 0..DEPTH as long as the read side never overtakes the write side.
  assign lvl_next = wbin_next - rbin;

  // In Gray code, "exactly DEPTH ahead" means the top two bits are inverted
  // and the rest are equal.
  assign full_gray = {~rq2[PW-1], ~rq2[PW-2], rq2[PW-3:0]};

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wbin        <= '0;
      w_ptr_gray  <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      w_level     <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      w_ptr_gray  <= wgray_next;
      full        <= (wgray_next == full_gray);
      almost_full <= (lvl_next >= PW'(AF_LEVEL));
      w_level     <= lvl_next;
      if (w_en && full)
        overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full: randomized and directed checks of wptr_full against a
// transaction-count model (total writes accepted, total reads, occupancy).
module tb_wptr_full;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam int AFM   = 4;

  logic          w_clk = 1'b0;
  logic          w_rst, w_en;
  logic [AW:0]   r_ptr_gray;
  logic          w_inc, full, almost_full, overflow;
  logic [AW-1:0] w_addr;
  logic [AW:0]   w_ptr_gray, w_level;

  wptr_full #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_en        (w_en),
    .r_ptr_gray  (r_ptr_gray),
    .w_inc       (w_inc),
    .w_addr      (w_addr),
    .w_ptr_gray  (w_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .w_level     (w_level),
    .overflow    (overflow)
  );

  always #5 w_clk = ~w_clk;

  int checks = 0;
  int errors = 0;

  // Model: unbounded counts of accepted writes and of reads, plus the read
  // count as seen through the two synchroniser stages.
  int wcnt, rcnt, rs1, rs2, occ;
  bit full_m, af_m, ovf_m;
  int lvl_m;
  logic [AW:0] gray_prev;

  function automatic logic [AW:0] to_gray(input int n);
    int m;
    m = n % (2 * DEPTH);
    return (AW+1)'(m ^ (m >> 1));
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One w_clk cycle: drive, check w_inc, update model at the edge, check outputs.
  task automatic step(input bit en, input bit rst, input bit radv);
    w_en  = en;
    w_rst = rst;
    if (rst) rcnt = 0;
    else if (radv && rcnt < wcnt) rcnt++;
    r_ptr_gray = to_gray(rcnt);
    #1;
    check("w_inc", int'(w_inc), int'(en && !full_m));
    @(posedge w_clk);
    if (rst) begin
      wcnt = 0; rs1 = 0; rs2 = 0;
      full_m = 0; af_m = 0; lvl_m = 0; ovf_m = 0;
    end else begin
      if (en && full_m) ovf_m = 1;
      if (en && !full_m) wcnt++;
      occ    = wcnt - rs2;
      full_m = (occ == DEPTH);
      af_m   = (occ >= DEPTH - AFM);
      lvl_m  = occ;
      rs2 = rs1;
      rs1 = rcnt;
    end
    @(negedge w_clk);
    check("w_addr", int'(w_addr), wcnt % DEPTH);
    check("w_ptr_gray", int'(w_ptr_gray), int'(to_gray(wcnt)));
    check("full", int'(full), int'(full_m));
    check("almost_full", int'(almost_full), int'(af_m));
    check("w_level", int'(w_level), lvl_m);
    check("overflow", int'(overflow), int'(ovf_m));
  endtask

  // Caller contract: the Gray read pointer moves at most one bit per edge.
  logic [AW:0] rp_prev = '0;
  always @(posedge w_clk) begin
    if (w_rst !== 1'b1)
      assert ($countones(r_ptr_gray ^ rp_prev) <= 1)
        else $error("r_ptr_gray changed more than one bit");
    rp_prev <= r_ptr_gray;
  end

  initial begin
    w_en = 1'b1; w_rst = 1'b1; r_ptr_gray = '0;
    wcnt = 0; rcnt = 0; rs1 = 0; rs2 = 0;
    full_m = 0; af_m = 0; lvl_m = 0; ovf_m = 0;
    @(negedge w_clk);

    // Reset with a pending write request.
    repeat (2) step(1, 1, 0);

    // Fill with the read pointer parked at 0.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    check("fill_gray", int'(w_ptr_gray), 'b110000);

    // Writes while full are dropped and latch overflow.
    repeat (3) step(1, 0, 0);
    step(0, 0, 0);
    check("ovf_sticky", int'(overflow), 1);

    // Release one entry: full clears on the 3rd edge.
    step(0, 0, 1);
    step(0, 0, 0);
    check("full_held", int'(full), 1);
    step(0, 0, 0);
    check("full_release", int'(full), 0);
    check("level_release", int'(w_level), DEPTH - 1);
    step(1, 0, 0);

    // Drain to a small level, then stream with the reader 4 behind.
    while (rcnt < wcnt - 4) step(0, 0, 1);
    repeat (4) step(0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      gray_prev = w_ptr_gray;
      step(1, 0, (wcnt - rcnt) > 4);
      check("gray_1bit", $countones(w_ptr_gray ^ gray_prev), 1);
      check("no_full", int'(full), 0);
    end

    // Mid-operation reset together with a write request.
    step(0, 1, 0);
    repeat (20) step(1, 0, 0);
    step(1, 1, 0);
    check("rst_ptr", int'(w_ptr_gray), 0);
    step(1, 0, 0);

    // Randomized phases: slow reader (reaches full), then fast reader.
    for (int i = 0; i < 300; i++)
      step(bit'($urandom_range(0, 3) != 0), 0, bit'($urandom_range(0, 3) == 0));
    for (int i = 0; i < 300; i++)
      step(bit'($urandom_range(0, 1)), 0, bit'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 100; i++)
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 40) == 0),
           bit'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
